// File: rtl/data_plane_rx_if.sv
// Bundle of node-id, packet stream and GPP read-side signals for data_plane_rx.
// Latency: none; this file only groups wires.
// Backpressure: none on the packet stream; the GPP pops with gpp_rd.
interface data_plane_rx_if #(
    parameter int ADDR_W = 4
);
    logic [15:0]     node_id;
    logic [31:0]     data_rx_packet;
    logic            gpp_rd;
    logic [15:0]     rx_data_out;
    logic [15:0]     rx_src_id;
    logic [ADDR_W:0] rx_count;
    logic            rx_empty;
    logic            rx_done;
    logic            rx_drop;
    logic            rx_abort;

    // Environment side: supplies the node id and the packet stream, and pops words.
    modport master (
        output node_id, data_rx_packet, gpp_rd,
        input  rx_data_out, rx_src_id, rx_count, rx_empty, rx_done, rx_drop, rx_abort
    );

    // Receiver side.
    modport slave (
        input  node_id, data_rx_packet, gpp_rd,
        output rx_data_out, rx_src_id, rx_count, rx_empty, rx_done, rx_drop, rx_abort
    );
endinterface

// File: rtl/data_plane_rx.sv
// Data plane receiver: matches packets addressed to node_id and buffers whole messages for the GPP.
// Latency: last payload beat is readable one cycle later, together with the rx_done pulse.
// Backpressure: none upstream; a message is dropped (rx_drop) if the FIFO lacks room at its header.
module data_plane_rx #(
    parameter int ADDR_W    = 4,
    parameter int PKT_WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    data_plane_rx_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam int BW    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t          state_q;
    logic [BW-1:0]   beat_q;
    logic [15:0]     src_hold_q;
    logic [15:0]     rx_src_id_q;
    logic            rx_done_q;
    logic            rx_drop_q;
    logic            rx_abort_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   commit_ptr_q;
    logic [15:0]     mem_q [DEPTH];

    logic            pkt_match;
    logic            last_beat;
    logic [PW-1:0]   used_words;
    logic [PW:0]     free_space;
    logic            has_room;
    logic [PW-1:0]   count_d;
    logic            pop;
    logic            wr_en;

    // An all-zero word is the idle packet and never matches, even for a zero address field.
    assign pkt_match  = (bus.data_rx_packet != 32'd0) && (bus.data_rx_packet[31:16] == bus.node_id);
    assign last_beat  = (beat_q == BW'(PKT_WORDS - 1));
    // Room is measured against wr_ptr so an in-flight message would also be accounted for.
    assign used_words = wr_ptr_q - rd_ptr_q;
    assign free_space = (PW + 1)'(DEPTH) - {1'b0, used_words};
    assign has_room   = (free_space >= (PW + 1)'(PKT_WORDS));
    // Only committed words are visible to the GPP.
    assign count_d    = commit_ptr_q - rd_ptr_q;
    assign pop        = bus.gpp_rd && (count_d != '0);
    assign wr_en      = (state_q == RECV) && pkt_match;

    assign bus.rx_data_out = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign bus.rx_count    = count_d;
    assign bus.rx_empty    = (count_d == '0);
    assign bus.rx_src_id   = rx_src_id_q;
    assign bus.rx_done     = rx_done_q;
    assign bus.rx_drop     = rx_drop_q;
    assign bus.rx_abort    = rx_abort_q;

    // Payload storage; contents are left unreset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.data_rx_packet[15:0];
        end
    end

    // Message FSM, pointer management and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            src_hold_q   <= '0;
            rx_src_id_q  <= '0;
            rx_done_q    <= 1'b0;
            rx_drop_q    <= 1'b0;
            rx_abort_q   <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
        end else begin
            rx_done_q  <= 1'b0;
            rx_drop_q  <= 1'b0;
            rx_abort_q <= 1'b0;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (pkt_match) begin
                        src_hold_q <= bus.data_rx_packet[15:0];
                        beat_q     <= '0;
                        if (has_room) begin
                            state_q <= RECV;
                        end else begin
                            state_q   <= DROP;
                            rx_drop_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (pkt_match) begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        beat_q   <= beat_q + BW'(1);
                        if (last_beat) begin
                            commit_ptr_q <= wr_ptr_q + PW'(1);
                            rx_src_id_q  <= src_hold_q;
                            rx_done_q    <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end else begin
                        // Truncated message: discard everything written since the last commit.
                        wr_ptr_q   <= commit_ptr_q;
                        rx_abort_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                DROP: begin
                    if (pkt_match) begin
                        beat_q <= beat_q + BW'(1);
                        if (last_beat) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_plane_rx.sv
// Self-checking bench for data_plane_rx: directed message sequences with a word scoreboard.
// Latency: checks rx_done/rx_count one cycle after the last payload beat.
// Backpressure: exercises drop on a nearly full FIFO and pops while receiving.
module tb_data_plane_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_plane_rx_if #(.ADDR_W(4)) bus ();

    data_plane_rx #(.ADDR_W(4), .PKT_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int n_done = 0, n_drop = 0, n_abort = 0, n_pops = 0;
    int d0, p0, a0, r0;
    logic [15:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one packet word for one cycle; if popping a committed word, compare the head first.
    task automatic tick(input logic [31:0] pkt, input logic rd);
        logic [15:0] exp_w;
        bus.data_rx_packet = pkt;
        bus.gpp_rd         = rd;
        #2;
        if (rd && bus.rx_count != 0) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sb_nonempty: observed=popped word expected=no word available");
            end
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
                check("pop_word", {16'd0, bus.rx_data_out}, {16'd0, exp_w});
            end
            n_pops++;
        end
        @(posedge clk);
        #1;
        n_done  += int'(bus.rx_done);
        n_drop  += int'(bus.rx_drop);
        n_abort += int'(bus.rx_abort);
    endtask

    // Header plus PKT_WORDS payload beats addressed to node 5; push words if a commit is expected.
    task automatic send_msg(input logic [15:0] src, input logic [3:0][15:0] w, input logic expect_commit);
        tick({16'h0005, src}, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (expect_commit) sb.push_back(w[i]);
            tick({16'h0005, w[i]}, 1'b0);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(32'd0, 1'b1);
    endtask

    initial begin
        bus.node_id        = 16'h0005;
        bus.data_rx_packet = 32'd0;
        bus.gpp_rd         = 1'b0;
        rst                = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_count", 32'(bus.rx_count), 32'd0);
        check("reset_empty", 32'(bus.rx_empty), 32'd1);
        check("reset_src", 32'(bus.rx_src_id), 32'd0);
        check("reset_pulses", {29'd0, bus.rx_done, bus.rx_drop, bus.rx_abort}, 32'd0);
        rst = 1'b0;
        tick(32'd0, 1'b0);

        // Basic message
        send_msg(16'h0009, {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1}, 1'b1);
        check("t1_done_pulse", 32'(bus.rx_done), 32'd1);
        check("t1_src", 32'(bus.rx_src_id), 32'h9);
        check("t1_count", 32'(bus.rx_count), 32'd4);
        tick(32'd0, 1'b0);
        check("t1_done_low", 32'(bus.rx_done), 32'd0);
        check("t1_done_once", 32'(n_done), 32'd1);
        drain(4);
        check("t1_empty", 32'(bus.rx_empty), 32'd1);
        check("t1_pops", 32'(n_pops), 32'd4);

        // Traffic for another node is ignored
        d0 = n_done; r0 = n_drop; a0 = n_abort;
        tick({16'h0007, 16'h0009}, 1'b0);
        for (int i = 0; i < 4; i++) tick({16'h0007, 16'hB0 + 16'(i)}, 1'b0);
        check("t2_count", 32'(bus.rx_count), 32'd0);
        check("t2_pulses", 32'(n_done - d0 + n_drop - r0 + n_abort - a0), 32'd0);
        check("t2_src_kept", 32'(bus.rx_src_id), 32'h9);
        tick(32'd0, 1'b1);
        tick(32'd0, 1'b1);
        check("empty_pop_ignored", 32'(bus.rx_count), 32'd0);

        // Truncated message, then a normal one
        a0 = n_abort; d0 = n_done;
        tick({16'h0005, 16'h0009}, 1'b0);
        tick({16'h0005, 16'h00B1}, 1'b0);
        tick({16'h0005, 16'h00B2}, 1'b0);
        tick(32'd0, 1'b0);
        check("t3_abort_pulse", 32'(bus.rx_abort), 32'd1);
        check("t3_count", 32'(bus.rx_count), 32'd0);
        check("t3_no_done", 32'(n_done - d0), 32'd0);
        tick(32'd0, 1'b0);
        send_msg(16'h0033, {16'h00C4, 16'h00C3, 16'h00C2, 16'h00C1}, 1'b1);
        check("t3_src", 32'(bus.rx_src_id), 32'h33);
        check("t3_count_after", 32'(bus.rx_count), 32'd4);
        drain(4);
        check("t3_abort_once", 32'(n_abort - a0), 32'd1);

        // Fill to 12, fourth accepted
        d0 = n_done; r0 = n_drop;
        for (int m = 0; m < 4; m++)
            send_msg(16'h0010 + 16'(m), {16'h1004 + 16'(m << 4), 16'h1003 + 16'(m << 4),
                                         16'h1002 + 16'(m << 4), 16'h1001 + 16'(m << 4)}, 1'b1);
        check("t4_full_count", 32'(bus.rx_count), 32'd16);
        check("t4_four_done", 32'(n_done - d0), 32'd4);
        check("t4_no_drop", 32'(n_drop - r0), 32'd0);
        drain(16);
        check("t4_drained", 32'(bus.rx_empty), 32'd1);

        // 14 committed words: next message dropped, then accepted after two pops
        for (int m = 0; m < 4; m++)
            send_msg(16'h0020 + 16'(m), {16'h2004 + 16'(m << 4), 16'h2003 + 16'(m << 4),
                                         16'h2002 + 16'(m << 4), 16'h2001 + 16'(m << 4)}, 1'b1);
        drain(2);
        check("t4_count14", 32'(bus.rx_count), 32'd14);
        d0 = n_done; r0 = n_drop;
        tick({16'h0005, 16'h00EE}, 1'b0);
        check("t4_drop_pulse", 32'(bus.rx_drop), 32'd1);
        for (int i = 0; i < 4; i++) tick({16'h0005, 16'hDD00 + 16'(i)}, 1'b0);
        check("t4_count_kept", 32'(bus.rx_count), 32'd14);
        check("t4_src_kept", 32'(bus.rx_src_id), 32'h23);
        check("t4_drop_once", 32'(n_drop - r0), 32'd1);
        check("t4_no_done_on_drop", 32'(n_done - d0), 32'd0);
        drain(2);
        send_msg(16'h0044, {16'h4404, 16'h4403, 16'h4402, 16'h4401}, 1'b1);
        check("t4_accept_after_pop", 32'(bus.rx_count), 32'd16);
        check("t4_src_new", 32'(bus.rx_src_id), 32'h44);
        drain(16);
        check("t4_empty_end", 32'(bus.rx_empty), 32'd1);

        // Back-to-back messages with continuous popping
        d0 = n_done; p0 = n_pops;
        for (int m = 0; m < 2; m++) begin
            tick({16'h0005, 16'h0050 + 16'(m)}, bus.rx_count != 0);
            for (int i = 0; i < 4; i++) begin
                sb.push_back(16'h5000 + 16'(m * 16 + i));
                tick({16'h0005, 16'h5000 + 16'(m * 16 + i)}, bus.rx_count != 0);
            end
        end
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick(32'd0, 1'b1);
        check("t5_sb_drained", 32'(sb.size()), 32'd0);
        check("t5_pops", 32'(n_pops - p0), 32'd8);
        check("t5_two_done", 32'(n_done - d0), 32'd2);
        check("t5_src", 32'(bus.rx_src_id), 32'h51);
        check("t5_empty", 32'(bus.rx_empty), 32'd1);

        // Reset during the second payload beat
        tick({16'h0005, 16'h0077}, 1'b0);
        tick({16'h0005, 16'h00D1}, 1'b0);
        rst = 1'b1;
        tick({16'h0005, 16'h00D2}, 1'b0);
        rst = 1'b0;
        check("t6_count", 32'(bus.rx_count), 32'd0);
        check("t6_empty", 32'(bus.rx_empty), 32'd1);
        check("t6_src", 32'(bus.rx_src_id), 32'd0);
        check("t6_pulses", {29'd0, bus.rx_done, bus.rx_drop, bus.rx_abort}, 32'd0);
        tick(32'd0, 1'b0);
        send_msg(16'h0042, {16'h00E4, 16'h00E3, 16'h00E2, 16'h00E1}, 1'b1);
        check("t6_src_after", 32'(bus.rx_src_id), 32'h42);
        check("t6_count_after", 32'(bus.rx_count), 32'd4);
        drain(4);
        check("t6_empty_end", 32'(bus.rx_empty), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end
endmodule
